// File: rtl/nec_ir_tx_framer_pkg.sv
// Shared definitions for the NEC IR transmit framer: state encodings,
// NEC unit durations and a mark-state helper.
package nec_ir_tx_framer_pkg;

   localparam logic [2:0] ST_IDLE         = 3'd0;
   localparam logic [2:0] ST_LEADER_MARK  = 3'd1;
   localparam logic [2:0] ST_LEADER_SPACE = 3'd2;
   localparam logic [2:0] ST_BIT_MARK     = 3'd3;
   localparam logic [2:0] ST_BIT_SPACE    = 3'd4;
   localparam logic [2:0] ST_STOP_MARK    = 3'd5;

   localparam logic [4:0] NEC_LEADER_MARK_U  = 5'd16;
   localparam logic [4:0] NEC_LEADER_SPACE_U = 5'd8;
   localparam logic [4:0] NEC_BIT_MARK_U     = 5'd1;
   localparam logic [4:0] NEC_ZERO_SPACE_U   = 5'd1;
   localparam logic [4:0] NEC_ONE_SPACE_U    = 5'd3;
   localparam logic [4:0] NEC_STOP_MARK_U    = 5'd1;
   localparam int unsigned NEC_DATA_BITS     = 32;

   function automatic logic is_mark_state(input logic [2:0] st);
      return (st == ST_LEADER_MARK) || (st == ST_BIT_MARK) || (st == ST_STOP_MARK);
   endfunction

endpackage

// File: rtl/nec_ir_tx_framer_carrier_gen.sv
// Carrier half-period generator: phase toggles every div+1 cycles and is
// forced high with a fresh count on restart.
module nec_ir_carrier_gen
   import nec_ir_tx_framer_pkg::*;
#(
   parameter int unsigned CDIV_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              restart,
   input  logic [CDIV_W-1:0] div,
   output logic              phase
);

   logic [CDIV_W-1:0] cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt   <= '0;
         phase <= 1'b0;
      end else if (restart) begin
         cnt   <= '0;
         phase <= 1'b1;
      end else if (cnt == div) begin
         cnt   <= '0;
         phase <= ~phase;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/nec_ir_tx_framer.sv
// NEC IR transmit framer: pops one 32-bit word from the frame FIFO and sends
// leader, 32 LSB-first data bits and a stop mark on ir_tx.
module nec_ir_tx_framer
   import nec_ir_tx_framer_pkg::*;
#(
   parameter int unsigned UDIV_W = 16,
   parameter int unsigned CDIV_W = 12
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear_n,
   input  logic              cfg_enable,
   input  logic              cfg_polarity,
   input  logic              cfg_carrier_en,
   input  logic [UDIV_W-1:0] cfg_unit_div,
   input  logic [CDIV_W-1:0] cfg_carrier_div,
   input  logic [31:0]       s_data,
   input  logic              s_valid,
   output logic              s_ready,
   output logic              ir_tx,
   output logic              busy,
   output logic              frame_done
);

   logic [2:0]        state;
   logic [2:0]        state_nxt;
   logic [UDIV_W-1:0] unit_div;
   logic [UDIV_W-1:0] unit_tmr;
   logic [UDIV_W-1:0] tmr_load;
   logic [CDIV_W-1:0] carrier_div;
   logic              carrier_en;
   logic [4:0]        unit_cnt;
   logic [4:0]        units_nxt;
   logic [5:0]        bit_idx;
   logic [31:0]       shreg;
   logic              accept;
   logic              unit_tick;
   logic              state_end;
   logic              last_bit;
   logic              enter;
   logic              restart;
   logic              phase;
   logic              mark_raw;

   assign s_ready   = (state == ST_IDLE) & cfg_enable & clear_n;
   assign accept    = s_valid & s_ready;
   assign unit_tick = (state != ST_IDLE) && (unit_tmr == '0);
   assign state_end = unit_tick && (unit_cnt == 5'd1);
   assign last_bit  = (bit_idx == 6'(NEC_DATA_BITS - 1));

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:         if (accept)    state_nxt = ST_LEADER_MARK;
         ST_LEADER_MARK:  if (state_end) state_nxt = ST_LEADER_SPACE;
         ST_LEADER_SPACE: if (state_end) state_nxt = ST_BIT_MARK;
         ST_BIT_MARK:     if (state_end) state_nxt = ST_BIT_SPACE;
         ST_BIT_SPACE:    if (state_end) state_nxt = last_bit ? ST_STOP_MARK : ST_BIT_MARK;
         ST_STOP_MARK:    if (state_end) state_nxt = ST_IDLE;
         default:         state_nxt = ST_IDLE;
      endcase
   end

   // BIT_SPACE is only entered from BIT_MARK, so shreg[0] is still the bit being sent
   always_comb begin
      units_nxt = '0;
      case (state_nxt)
         ST_LEADER_MARK:  units_nxt = NEC_LEADER_MARK_U;
         ST_LEADER_SPACE: units_nxt = NEC_LEADER_SPACE_U;
         ST_BIT_MARK:     units_nxt = NEC_BIT_MARK_U;
         ST_BIT_SPACE:    units_nxt = shreg[0] ? NEC_ONE_SPACE_U : NEC_ZERO_SPACE_U;
         ST_STOP_MARK:    units_nxt = NEC_STOP_MARK_U;
         default:         units_nxt = '0;
      endcase
   end

   always_comb begin
      tmr_load = unit_div;
      if (accept)
         tmr_load = cfg_unit_div;
      else if (state_nxt == ST_IDLE)
         tmr_load = '0;
   end

   assign enter    = (state_nxt != state);
   assign restart  = clear_n & enter & is_mark_state(state_nxt);
   assign mark_raw = is_mark_state(state) & (carrier_en ? phase : 1'b1);

   nec_ir_carrier_gen #(
      .CDIV_W (CDIV_W)
   ) u_carrier (
      .clk     (clk),
      .rst_n   (rst_n),
      .restart (restart),
      .div     (carrier_div),
      .phase   (phase)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         busy        <= 1'b0;
         frame_done  <= 1'b0;
         ir_tx       <= 1'b0;
         unit_tmr    <= '0;
         unit_cnt    <= '0;
         bit_idx     <= '0;
         shreg       <= '0;
         unit_div    <= '0;
         carrier_div <= '0;
         carrier_en  <= 1'b0;
      end else if (!clear_n) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         ir_tx      <= cfg_polarity;
         unit_tmr   <= '0;
         unit_cnt   <= '0;
         bit_idx    <= '0;
      end else begin
         state      <= state_nxt;
         busy       <= (state_nxt != ST_IDLE);
         frame_done <= (state == ST_STOP_MARK) && state_end;
         ir_tx      <= mark_raw ^ cfg_polarity;

         if (accept) begin
            shreg       <= s_data;
            unit_div    <= cfg_unit_div;
            carrier_div <= cfg_carrier_div;
            carrier_en  <= cfg_carrier_en;
            bit_idx     <= '0;
         end

         if (enter) begin
            unit_tmr <= tmr_load;
            unit_cnt <= units_nxt;
         end else if (unit_tick) begin
            unit_tmr <= unit_div;
            unit_cnt <= unit_cnt - 1'b1;
         end else if (state != ST_IDLE) begin
            unit_tmr <= unit_tmr - 1'b1;
         end

         if ((state == ST_BIT_SPACE) && state_end) begin
            shreg   <= shreg >> 1;
            bit_idx <= bit_idx + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_nec_ir_tx_framer.sv
// Directed self-checking bench for nec_ir_tx_framer: frame timing, data
// encoding, carrier/polarity, back-to-back, abort, enable gating and reset.
`timescale 1ns/1ps
module tb_nec_ir_tx_framer;

   localparam int unsigned UDIV_W = 16;
   localparam int unsigned CDIV_W = 12;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clear_n;
   logic              cfg_enable;
   logic              cfg_polarity;
   logic              cfg_carrier_en;
   logic [UDIV_W-1:0] cfg_unit_div;
   logic [CDIV_W-1:0] cfg_carrier_div;
   logic [31:0]       s_data;
   logic              s_valid;
   logic              s_ready;
   logic              ir_tx;
   logic              busy;
   logic              frame_done;

   int checks = 0;
   int errors = 0;

   int cyc = 0;
   int busy_cnt = 0;
   int done_cnt = 0;
   int acc_cnt = 0;
   int last_acc_cyc = 0;
   int last_done_cyc = 0;

   bit exp_q[$];

   always #5 clk = ~clk;

   nec_ir_tx_framer #(
      .UDIV_W (UDIV_W),
      .CDIV_W (CDIV_W)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .clear_n         (clear_n),
      .cfg_enable      (cfg_enable),
      .cfg_polarity    (cfg_polarity),
      .cfg_carrier_en  (cfg_carrier_en),
      .cfg_unit_div    (cfg_unit_div),
      .cfg_carrier_div (cfg_carrier_div),
      .s_data          (s_data),
      .s_valid         (s_valid),
      .s_ready         (s_ready),
      .ir_tx           (ir_tx),
      .busy            (busy),
      .frame_done      (frame_done)
   );

   // Cycle-level bookkeeping sampled mid-cycle
   always @(negedge clk) begin
      if (busy === 1'b1) busy_cnt++;
      if (frame_done === 1'b1) begin
         done_cnt++;
         last_done_cyc = cyc;
      end
      if (s_valid === 1'b1 && s_ready === 1'b1) begin
         acc_cnt++;
         last_acc_cyc = cyc;
      end
      cyc++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] req);
      checks++;
      assert (obs === req) else begin
         errors++;
         $error("FAIL %s: observed %0d required %0d", tag, obs, req);
      end
   endtask

   task automatic push_seg(input bit mark, input int n, input int c, input bit e, input bit pol);
      for (int j = 0; j < n; j++)
         exp_q.push_back((mark && (!e || ((j / (c + 1)) % 2 == 0))) ^ pol);
   endtask

   task automatic build_exp(input logic [31:0] data);
      int u;
      int c;
      bit e;
      bit p;
      u = int'(cfg_unit_div) + 1;
      c = int'(cfg_carrier_div);
      e = cfg_carrier_en;
      p = cfg_polarity;
      exp_q.delete();
      push_seg(1'b1, 16 * u, c, e, p);
      push_seg(1'b0, 8 * u, c, e, p);
      for (int i = 0; i < 32; i++) begin
         push_seg(1'b1, u, c, e, p);
         push_seg(1'b0, (data[i] ? 3 : 1) * u, c, e, p);
      end
      push_seg(1'b1, u, c, e, p);
   endtask

   task automatic wait_accept(input string tag, output bit ok);
      ok = 1'b0;
      #1;
      for (int i = 0; i < 2000; i++) begin
         if (s_valid === 1'b1 && s_ready === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) chk({tag, "_accept_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic send_frame(input logic [31:0] data, input int len_req, input string tag,
                             input bit scramble);
      bit                ok;
      bit                pol;
      int                mism;
      int                b0;
      int                d0;
      int                a0;
      logic [UDIV_W-1:0] sv_d;
      logic [CDIV_W-1:0] sv_c;
      logic              sv_e;
      build_exp(data);
      pol  = cfg_polarity;
      sv_d = cfg_unit_div;
      sv_c = cfg_carrier_div;
      sv_e = cfg_carrier_en;
      b0 = busy_cnt;
      d0 = done_cnt;
      a0 = acc_cnt;
      s_data  = data;
      s_valid = 1'b1;
      wait_accept(tag, ok);
      if (!ok) begin
         s_valid = 1'b0;
         return;
      end
      tick();
      s_valid = 1'b0;
      chk({tag, "_busy_start"}, 64'(busy), 64'd1);
      if (scramble) begin
         cfg_unit_div    = 16'd3;
         cfg_carrier_div = 12'd7;
         cfg_carrier_en  = ~sv_e;
      end
      mism = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
         tick();
         if (ir_tx !== exp_q[k]) mism++;
      end
      chk({tag, "_wave_mismatches"}, 64'(mism), 64'd0);
      chk({tag, "_done_pulse"}, 64'(frame_done), 64'd1);
      chk({tag, "_busy_end"}, 64'(busy), 64'd0);
      tick();
      chk({tag, "_idle_level"}, 64'(ir_tx), 64'(pol));
      chk({tag, "_done_low"}, 64'(frame_done), 64'd0);
      chk({tag, "_busy_len"}, 64'(busy_cnt - b0), 64'(len_req));
      chk({tag, "_done_count"}, 64'(done_cnt - d0), 64'd1);
      chk({tag, "_accept_count"}, 64'(acc_cnt - a0), 64'd1);
      cfg_unit_div    = sv_d;
      cfg_carrier_div = sv_c;
      cfg_carrier_en  = sv_e;
   endtask

   initial begin
      bit ok;
      int a0;
      int d0;
      int b0;
      int acc1;
      int acc2;
      int rdy_hi;

      rst_n           = 1'b0;
      clear_n         = 1'b1;
      cfg_enable      = 1'b0;
      cfg_polarity    = 1'b1;
      cfg_carrier_en  = 1'b0;
      cfg_unit_div    = 16'd9;
      cfg_carrier_div = 12'd2;
      s_data          = 32'h0;
      s_valid         = 1'b0;
      repeat (3) tick();

      chk("reset_s_ready", 64'(s_ready), 64'd0);
      chk("reset_ir_tx", 64'(ir_tx), 64'd0);
      chk("reset_busy", 64'(busy), 64'd0);
      chk("reset_frame_done", 64'(frame_done), 64'd0);

      rst_n        = 1'b1;
      cfg_polarity = 1'b0;
      cfg_enable   = 1'b1;
      repeat (2) tick();

      // All-zero frame, D=9, steady marks
      send_frame(32'h0000_0000, 890, "zeros", 1'b0);

      // Mixed data with config scrambled mid-frame
      send_frame(32'hA5A5_A5A5, 1210, "a5a5", 1'b1);

      // Carrier with inverted output, config scrambled mid-frame
      cfg_carrier_en  = 1'b1;
      cfg_carrier_div = 12'd2;
      cfg_polarity    = 1'b1;
      send_frame(32'h0000_FFFF, 1210, "carrier_pol", 1'b1);

      // Minimum dividers: 1 cycle per unit, carrier toggling every cycle
      cfg_unit_div    = 16'd0;
      cfg_carrier_div = 12'd0;
      cfg_polarity    = 1'b0;
      send_frame(32'h8000_0001, 93, "min_div", 1'b0);
      cfg_carrier_en = 1'b0;

      // Back-to-back from a two-word FIFO, D=0
      a0 = acc_cnt;
      d0 = done_cnt;
      b0 = busy_cnt;
      s_data  = 32'h0000_0001;
      s_valid = 1'b1;
      wait_accept("b2b_first", ok);
      tick();
      acc1   = last_acc_cyc;
      s_data = 32'hFFFF_FFFF;
      wait_accept("b2b_second", ok);
      chk("b2b_accept_with_done", 64'(frame_done), 64'd1);
      tick();
      s_valid = 1'b0;
      acc2 = last_acc_cyc;
      chk("b2b_accept_gap", 64'(acc2 - acc1), 64'd92);
      ok = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (frame_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("b2b_second_done_seen", 64'(ok), 64'd1);
      tick();
      chk("b2b_second_len", 64'(last_done_cyc - acc2), 64'd154);
      chk("b2b_busy_total", 64'(busy_cnt - b0), 64'd244);
      chk("b2b_done_count", 64'(done_cnt - d0), 64'd2);
      chk("b2b_accept_count", 64'(acc_cnt - a0), 64'd2);

      // Abort during LEADER_SPACE
      cfg_unit_div = 16'd9;
      a0 = acc_cnt;
      d0 = done_cnt;
      s_data  = 32'h1234_5678;
      s_valid = 1'b1;
      wait_accept("abort", ok);
      tick();
      s_valid = 1'b0;
      repeat (170) tick();
      chk("abort_in_frame", 64'(busy), 64'd1);
      clear_n      = 1'b0;
      cfg_polarity = 1'b1;
      #1;
      chk("abort_ready_low", 64'(s_ready), 64'd0);
      tick();
      clear_n = 1'b1;
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_ir_tx", 64'(ir_tx), 64'd1);
      chk("abort_no_done", 64'(frame_done), 64'd0);
      repeat (300) tick();
      chk("abort_done_count", 64'(done_cnt - d0), 64'd0);
      chk("abort_accept_count", 64'(acc_cnt - a0), 64'd1);
      chk("abort_still_idle", 64'(busy), 64'd0);
      send_frame(32'h0F0F_0F0F, 1210, "post_abort", 1'b0);
      cfg_polarity = 1'b0;

      // Enable gating and mid-frame disable
      cfg_unit_div = 16'd0;
      cfg_enable   = 1'b0;
      a0 = acc_cnt;
      d0 = done_cnt;
      s_data  = 32'h0000_0000;
      s_valid = 1'b1;
      rdy_hi  = 0;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (s_ready !== 1'b0) rdy_hi++;
      end
      chk("gate_ready_low", 64'(rdy_hi), 64'd0);
      chk("gate_no_accept", 64'(acc_cnt - a0), 64'd0);
      cfg_enable = 1'b1;
      wait_accept("gate", ok);
      tick();
      cfg_enable = 1'b0;
      s_data     = 32'hDEAD_BEEF;
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         if (frame_done === 1'b1) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("gate_done_seen", 64'(ok), 64'd1);
      repeat (50) tick();
      chk("gate_accept_count", 64'(acc_cnt - a0), 64'd1);
      chk("gate_done_count", 64'(done_cnt - d0), 64'd1);
      chk("gate_ready_after", 64'(s_ready), 64'd0);
      s_valid    = 1'b0;
      cfg_enable = 1'b1;

      // Async reset mid-frame
      cfg_unit_div = 16'd9;
      cfg_polarity = 1'b1;
      s_data  = 32'h0000_0000;
      s_valid = 1'b1;
      wait_accept("async_rst", ok);
      tick();
      s_valid = 1'b0;
      repeat (165) tick();
      chk("async_rst_space_level", 64'(ir_tx), 64'd1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_ir_tx", 64'(ir_tx), 64'd0);
      chk("async_rst_busy", 64'(busy), 64'd0);
      chk("async_rst_done", 64'(frame_done), 64'd0);
      tick();
      rst_n        = 1'b1;
      cfg_polarity = 1'b0;
      repeat (3) tick();
      chk("async_rst_recovered_idle", 64'(busy), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/nec_ir_tx_framer.md
Name: nec_ir_tx_framer

Overview:
- Transmit stage that drains the read side of a 32-bit frame FIFO and emits NEC-format IR frames on a single output pin.
- One consumed 32-bit word produces one complete frame: leader, 32 data bits sent LSB first, then a stop mark.
- Optional carrier modulation and output polarity are configurable.
- Sits between the TX frame FIFO's read port and the IR LED pad.

Parameters:
- UDIV_W, 16, width of cfg_unit_div.
- CDIV_W, 12, width of cfg_carrier_div.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active low
- clear_n  in  1  synchronous clear, active low; aborts any frame
- cfg_enable  in  1  permits accepting new frames
- cfg_polarity  in  1  0: mark drives ir_tx=1; 1: output inverted
- cfg_carrier_en  in  1  1: marks are carrier-modulated; 0: marks are steady level
- cfg_unit_div  in  UDIV_W  clk cycles per NEC unit (562.5 us) minus 1
- cfg_carrier_div  in  CDIV_W  clk cycles per carrier half-period minus 1
- s_data  in  32  frame word; bit0 is transmitted first
- s_valid  in  1  frame word available (driven by the FIFO's rd_valid)
- s_ready  out  1  frame word consumed (drives the FIFO's rd_ready)
- ir_tx  out  1  IR output, registered
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse when a frame completes normally

Behaviour:
- Reset values: s_ready=0, ir_tx=0, busy=0, frame_done=0, state=IDLE, all counters 0.
- s_ready = (state==IDLE) & cfg_enable & clear_n. Purely combinational, with no dependency on s_valid.
- Accept: s_valid & s_ready in cycle N.
  - Latch s_data into a 32-bit shift register.
  - Latch cfg_unit_div into D, cfg_carrier_div into C, cfg_carrier_en into E.
  - Enter LEADER_MARK at N+1.
  - Config changes mid-frame have no effect on that frame.
- Unit timer: down-counter loaded with D on every state entry. It produces a unit tick when it reaches 0, then reloads. One unit = D+1 cycles.
- Unit counter: holds the number of units remaining in the current state.
- States and unit durations:
  - IDLE: no mark.
  - LEADER_MARK: 16 units, mark.
  - LEADER_SPACE: 8 units.
  - BIT_MARK: 1 unit, mark.
  - BIT_SPACE: 1 unit if the current bit is 0, 3 units if it is 1.
  - STOP_MARK: 1 unit, mark.
- Transitions:
  - At the end of BIT_SPACE, shift the register right and increment the bit index (6 bits).
  - After bit index 31, go to STOP_MARK; otherwise go to BIT_MARK.
  - At the end of STOP_MARK, go to IDLE and assert frame_done for exactly that one cycle.
  - s_ready may be high in the same cycle as frame_done, so back-to-back frames are allowed.
- Frame length:
  - (24 + 32*2 + 1 + 2*popcount(data)) * (D+1) cycles in non-IDLE states.
  - All zeros: 89 units. All ones: 153 units.
- busy = (state != IDLE), registered with state.
- Carrier:
  - Half-period counter and phase are reset (phase=1) on every entry into a mark state.
  - The phase toggles every C+1 cycles while in a mark state.
- Output equation: mark_raw = mark_state & (E ? phase : 1). Then ir_tx <= mark_raw ^ cfg_polarity.
  - ir_tx is registered, so the pin lags state by 1 cycle.
  - cfg_polarity is applied live, not latched.
- clear_n low:
  - Next edge: state=IDLE, counters cleared, busy=0, ir_tx=cfg_polarity, no frame_done.
  - No word is accepted while clear_n is low.
- cfg_enable dropped mid-frame: the current frame completes normally; no new accept follows.
- D=0 is legal, giving 1 cycle per unit. C=0 is legal, so the carrier toggles every cycle.
- Async reset asserted mid-frame: all outputs return to their reset values immediately and the frame is lost.

Decomposition:
- Shared header nec_ir_defs.vh:
  - State encodings (3-bit).
  - NEC_LEADER_MARK_U=16, NEC_LEADER_SPACE_U=8, NEC_BIT_MARK_U=1, NEC_ZERO_SPACE_U=1, NEC_ONE_SPACE_U=3, NEC_STOP_MARK_U=1, NEC_DATA_BITS=32.
- One sub-module, nec_ir_carrier_gen:
  - Half-period counter plus phase flop.
  - Inputs: clk, rst_n, restart, div.
  - Output: phase.

Test Plan:
- Timing, all-zero frame: D=9, E=0, pol=0; push 0x00000000. Required response:
  - s_ready pulses once.
  - ir_tx=1 for 160 cycles starting at N+2, then 0 for 80.
  - Then 32 repeats of (1 for 10, 0 for 10), then 1 for 10.
  - busy high for 890 cycles; frame_done pulses once at the end.
- Data encoding: D=9; push 0xA5A5A5A5 (LSB first: 1,0,1,0,0,1,0,1...). Required response:
  - Each 1 bit shows a space of 30 cycles; each 0 bit shows a space of 10 cycles.
  - busy lasts (89+32)*10 = 1210 cycles.
- Carrier and polarity: D=9, E=1, C=2, pol=1. Required response:
  - During the leader mark, ir_tx alternates 0,0,0,1,1,1... starting low.
  - During spaces, ir_tx holds 1.
- Back-to-back with a 2-entry FIFO instance: D=0, push 0x00000001 and 0xFFFFFFFF. Required response:
  - The second accept occurs in the same cycle as the first frame_done.
  - Frame lengths are 91 and 153 cycles respectively.
- Abort: clear_n low for 1 cycle during LEADER_SPACE. Required response:
  - Next cycle busy=0 and ir_tx=pol.
  - No frame_done.
  - The FIFO word is not re-read.
  - The next frame transmits normally.
- Enable gating: with cfg_enable=0 and s_valid=1, s_ready stays 0 for 100 cycles. Drop cfg_enable mid-frame: the frame finishes with frame_done, and no further accept occurs.
